if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage between the PC and the decode stage. It generates the 30-bit word fetch address `if_pc` for the L1 instruction cache and consumes the cache's `insn` / `data_rdy` / `if_busy`. It registers accepted instructions into the IF/ID pipeline register. It also handles downstream stall, flush and branch redirect, including redirects that arrive while a cache miss is outstanding.

## Interface

Parameters:
- `RESET_PC`, 30'h0, word address fetched first after reset.
- `NOP_INSN`, 32'h0000_0013, instruction word inserted as a bubble.
- `CNT_W`, 16, width of the miss-cycle counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  decode stall; hold PC and IF/ID.
- `flush`  in  1  squash IF/ID contents.
- `br_taken`  in  1  redirect request, single-cycle pulse.
- `br_addr`  in  30  redirect target word address.
- `insn`  in  32  instruction from the L1 icache.
- `data_rdy`  in  1  icache hit; `insn` valid this cycle.
- `if_busy`  in  1  icache miss stall.
- `if_pc`  out  30  fetch address to the icache, registered.
- `id_insn`  out  32  IF/ID instruction.
- `id_pc`  out  30  IF/ID word PC.
- `id_en`  out  1  IF/ID valid.
- `redir_pend`  out  1  a redirect is held waiting for the miss to finish.
- `miss_cnt`  out  CNT_W  saturating count of cycles with `if_busy`=1.

## Operation

- Fetch accepted in a cycle with `data_rdy`=1, `if_busy`=0, `stall`=0, `flush`=0, `br_taken`=0, state FETCH:
  - IF/ID <= {`insn`, `if_pc`, valid 1}.
  - `if_pc` <= `if_pc`+1, modulo 2^30 (30'h3FFF_FFFF wraps to 0).
- No accept and `stall`=0: IF/ID <= bubble ({`NOP_INSN`, `id_pc` unchanged, `id_en`=0}). `if_pc` is held.
- `stall`=1 and `flush`=0: IF/ID held and `if_pc` held; `br_taken` still applies (see below).
- `flush`=1: IF/ID <= bubble regardless of `stall`.
- State machine with two states, FETCH and REDIR_WAIT:
  - FETCH, `br_taken`=1, `if_busy`=0: `if_pc` <= `br_addr`; IF/ID <= bubble; stay FETCH.
  - FETCH, `br_taken`=1, `if_busy`=1:
    - Latch `br_addr` into `pend_addr` and go to REDIR_WAIT.
    - `if_pc` is held, because the icache requires a stable address through the miss.
  - REDIR_WAIT:
    - No fetch is accepted; any `data_rdy` belongs to the stale path and is discarded. IF/ID <= bubble unless `stall`=1.
    - A new `br_taken` overwrites `pend_addr`.
    - When `if_busy`=0: `if_pc` <= `pend_addr` (or `br_addr` if `br_taken`=1 in the same cycle); go to FETCH.
- Priority for the next `if_pc`: `rst` > redirect > stall hold > increment.
- Priority for IF/ID: `rst` > `flush` > `br_taken` or REDIR_WAIT bubble > `stall` hold > accept/bubble.
- `miss_cnt` increments every cycle with `if_busy`=1 and saturates at all ones. It is cleared only by `rst`.
- `redir_pend` = (state == REDIR_WAIT), registered.

## Timing

- Reset values:
  - `if_pc`=`RESET_PC`, `id_insn`=`NOP_INSN`, `id_pc`=0, `id_en`=0.
  - `redir_pend`=0, `miss_cnt`=0, `pend_addr`=0, state FETCH.
- Reset mid-operation, including during REDIR_WAIT, discards the pending redirect at the next edge.
- Hit-path latency:
  - `if_pc`=A presented in cycle n with a hit → `id_insn`/`id_pc`=A/`id_en`=1 in cycle n+1, and `if_pc`=A+1 in cycle n+1.
  - Back-to-back hits give one instruction per cycle.
- Redirect latency:
  - `br_taken` in cycle n with no miss → `if_pc`=`br_addr` at n+1, and first target instruction in IF/ID at n+2.
  - With a miss → `if_pc` updates on the edge after the first cycle where `if_busy`=0.
- `if_pc` changes only on clock edges. It is never combinationally driven from `br_addr`.

## Test plan

- Reset, then continuous hits with `insn`=32'h1000_0000+pc → `if_pc` 0,1,2,3; `id_en`=1 from cycle 2 with `id_pc` 0,1,2 and matching `id_insn`.
- `if_busy`=1 for 5 cycles at `if_pc`=4 → `if_pc` held at 4; `id_en`=0 throughout; `miss_cnt`=5; the fetch resumes with `id_pc`=4.
- `br_taken`, `br_addr`=30'h100, during a hit → next `if_pc`=30'h100; one bubble; `id_pc`=30'h100 two cycles after the branch.
- `br_taken` to 30'h200 at miss cycle 2 of 6 → `redir_pend`=1; `if_pc` held; the stale `data_rdy` is not registered (`id_en`=0); `if_pc`=30'h200 after `if_busy` falls; `redir_pend`=0.
- `stall`=1 and `flush`=1 together with `id_en`=1 → `id_en`=0 and `id_insn`=`NOP_INSN` next cycle; `if_pc` held.
- `if_pc`=30'h3FFF_FFFF with a hit → `if_pc` wraps to 0. With `CNT_W`=4 and 20 busy cycles → `miss_cnt`=15.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the word fetch address to the L1 icache,
// registers accepted instructions into the IF/ID pipeline register, and
// handles decode stall, flush and branch redirects. A redirect that arrives
// during an icache miss is parked in pend_addr until the miss completes,
// because the icache needs a stable address for the whole miss.
module if_fetch_stage #(
    parameter logic [29:0] RESET_PC = 30'h0,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_taken,
    input  logic [29:0]      br_addr,
    input  logic [31:0]      insn,
    input  logic             data_rdy,
    input  logic             if_busy,
    output logic [29:0]      if_pc,
    output logic [31:0]      id_insn,
    output logic [29:0]      id_pc,
    output logic             id_en,
    output logic             redir_pend,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [0:0] {
        FETCH      = 1'b0,
        REDIR_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [29:0]  pend_addr_r;
    logic [29:0]  pend_next_s;
    logic [29:0]  pc_next_s;
    logic         accept_s;
    logic         id_bubble_s;
    logic         id_load_s;

    // A hit is taken only in FETCH with nothing else competing for IF/ID.
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == FETCH) && data_rdy && !if_busy && !stall &&
            !flush && !br_taken) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next fetch address, next state and parked redirect target.
    always_comb begin
        pc_next_s    = if_pc;
        state_next_s = state_r;
        pend_next_s  = pend_addr_r;
        case (state_r)
            FETCH: begin
                if (br_taken) begin
                    if (if_busy) begin
                        // Miss in flight: keep if_pc stable, park the target.
                        pend_next_s  = br_addr;
                        state_next_s = REDIR_WAIT;
                    end else begin
                        pc_next_s = br_addr;
                    end
                end else if (accept_s) begin
                    // 30-bit add wraps 30'h3FFF_FFFF to zero naturally.
                    pc_next_s = if_pc + 30'd1;
                end else begin
                    pc_next_s = if_pc;
                end
            end
            REDIR_WAIT: begin
                if (!if_busy) begin
                    // A same-cycle redirect is the newest and wins.
                    if (br_taken) begin
                        pc_next_s = br_addr;
                    end else begin
                        pc_next_s = pend_addr_r;
                    end
                    state_next_s = FETCH;
                end else begin
                    if (br_taken) begin
                        pend_next_s = br_addr;
                    end else begin
                        pend_next_s = pend_addr_r;
                    end
                end
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // IF/ID update selection: flush and redirect force a bubble over stall;
    // otherwise stall holds, and an unaccepted cycle inserts a bubble.
    always_comb begin
        id_bubble_s = 1'b0;
        id_load_s   = 1'b0;
        if (flush || br_taken) begin
            id_bubble_s = 1'b1;
        end else if (stall) begin
            id_bubble_s = 1'b0;
        end else if (accept_s) begin
            id_load_s = 1'b1;
        end else begin
            id_bubble_s = 1'b1;
        end
    end

    // Fetch FSM with registered if_pc, parked target and redir_pend flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FETCH;
            pend_addr_r <= 30'h0;
            if_pc       <= RESET_PC;
            redir_pend  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pend_addr_r <= pend_next_s;
            if_pc       <= pc_next_s;
            redir_pend  <= (state_next_s == REDIR_WAIT);
        end
    end

    // IF/ID pipeline register; a bubble keeps id_pc for debug visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_insn <= NOP_INSN;
            id_pc   <= 30'h0;
            id_en   <= 1'b0;
        end else if (id_load_s) begin
            id_insn <= insn;
            id_pc   <= if_pc;
            id_en   <= 1'b1;
        end else if (id_bubble_s) begin
            id_insn <= NOP_INSN;
            id_pc   <= id_pc;
            id_en   <= 1'b0;
        end else begin
            id_insn <= id_insn;
            id_pc   <= id_pc;
            id_en   <= id_en;
        end
    end

    // Saturating count of icache miss cycles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt <= {CNT_W{1'b0}};
        end else if (if_busy && (miss_cnt != CNT_MAX)) begin
            miss_cnt <= miss_cnt + CNT_ONE;
        end else begin
            miss_cnt <= miss_cnt;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: hit streaming, miss hold, redirects with
// and without a miss, stall/flush, PC wrap, reset in REDIR_WAIT and counter
// saturation on a narrow-counter instance.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, br_taken, data_rdy, if_busy;
    logic [29:0] br_addr;
    logic [31:0] insn;
    logic [29:0] if_pc, id_pc;
    logic [31:0] id_insn;
    logic        id_en, redir_pend;
    logic [15:0] miss_cnt;

    logic        busy4;
    logic [29:0] if_pc4, id_pc4;
    logic [31:0] id_insn4;
    logic        id_en4, redir_pend4;
    logic [3:0]  miss_cnt4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Icache model: every hit returns 32'h1000_0000 + address.
    assign insn = 32'h1000_0000 + {2'b00, if_pc};

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_addr(br_addr), .insn(insn),
        .data_rdy(data_rdy), .if_busy(if_busy), .if_pc(if_pc),
        .id_insn(id_insn), .id_pc(id_pc), .id_en(id_en),
        .redir_pend(redir_pend), .miss_cnt(miss_cnt)
    );

    if_fetch_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
        .br_taken(1'b0), .br_addr(30'h0), .insn(32'h0),
        .data_rdy(1'b0), .if_busy(busy4), .if_pc(if_pc4),
        .id_insn(id_insn4), .id_pc(id_pc4), .id_en(id_en4),
        .redir_pend(redir_pend4), .miss_cnt(miss_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] ei, input logic [29:0] ep, input logic ee);
        check({tag, "_insn"}, id_insn, ei);
        check({tag, "_pc"}, {2'b00, id_pc}, {2'b00, ep});
        check({tag, "_en"}, {31'h0, id_en}, {31'h0, ee});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        br_addr = 30'h0; data_rdy = 1'b0; if_busy = 1'b0; busy4 = 1'b0;
        tick(); tick();
        check("rst_if_pc", {2'b00, if_pc}, 32'h0);
        chk_id("rst_id", NOP, 30'h0, 1'b0);
        check("rst_redir", {31'h0, redir_pend}, 32'h0);
        check("rst_miss", {16'h0, miss_cnt}, 32'h0);

        // Continuous hits from address 0.
        rst = 1'b0; data_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hit_if_pc", {2'b00, if_pc}, i + 1);
            chk_id("hit_id", 32'h1000_0000 + i, i[29:0], 1'b1);
        end

        // Five-cycle miss at if_pc 4.
        data_rdy = 1'b0; if_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("miss_if_pc", {2'b00, if_pc}, 32'd4);
            check("miss_id_en", {31'h0, id_en}, 32'h0);
        end
        check("miss_cnt5", {16'h0, miss_cnt}, 32'd5);
        if_busy = 1'b0; data_rdy = 1'b1;
        tick();
        chk_id("resume", 32'h1000_0004, 30'd4, 1'b1);
        check("resume_if_pc", {2'b00, if_pc}, 32'd5);

        // Redirect during a hit.
        br_taken = 1'b1; br_addr = 30'h100;
        tick();
        check("br_if_pc", {2'b00, if_pc}, 32'h100);
        chk_id("br_bubble", NOP, 30'd4, 1'b0);
        br_taken = 1'b0;
        tick();
        chk_id("br_target", 32'h1000_0100, 30'h100, 1'b1);
        check("br_if_pc2", {2'b00, if_pc}, 32'h101);

        // Redirect to 0x200 on miss cycle 2 of 6.
        data_rdy = 1'b0; if_busy = 1'b1;
        tick();
        check("rw_c1_redir", {31'h0, redir_pend}, 32'h0);
        br_taken = 1'b1; br_addr = 30'h200;
        tick();
        br_taken = 1'b0; br_addr = 30'h0;
        check("rw_c2_redir", {31'h0, redir_pend}, 32'h1);
        check("rw_c2_if_pc", {2'b00, if_pc}, 32'h101);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rw_hold_if_pc", {2'b00, if_pc}, 32'h101);
            check("rw_hold_redir", {31'h0, redir_pend}, 32'h1);
            check("rw_hold_en", {31'h0, id_en}, 32'h0);
        end
        check("rw_miss_cnt", {16'h0, miss_cnt}, 32'd11);
        // Miss ends with stale data for 0x101; it must not be registered.
        if_busy = 1'b0; data_rdy = 1'b1;
        tick();
        check("rw_end_if_pc", {2'b00, if_pc}, 32'h200);
        check("rw_end_redir", {31'h0, redir_pend}, 32'h0);
        chk_id("rw_stale", NOP, 30'h100, 1'b0);
        tick();
        chk_id("rw_target", 32'h1000_0200, 30'h200, 1'b1);

        // Stall together with flush squashes a valid IF/ID.
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_id("sf", NOP, 30'h200, 1'b0);
        check("sf_if_pc", {2'b00, if_pc}, 32'h201);
        flush = 1'b0; stall = 1'b0;
        tick();
        chk_id("post_sf", 32'h1000_0201, 30'h201, 1'b1);
        stall = 1'b1;
        tick();
        chk_id("stall_hold", 32'h1000_0201, 30'h201, 1'b1);
        check("stall_if_pc", {2'b00, if_pc}, 32'h202);
        stall = 1'b0;

        // PC wrap at the top of the address space.
        br_taken = 1'b1; br_addr = 30'h3FFF_FFFF;
        tick();
        check("wrap_pre", {2'b00, if_pc}, 32'h3FFF_FFFF);
        br_taken = 1'b0;
        tick();
        check("wrap_if_pc", {2'b00, if_pc}, 32'h0);
        chk_id("wrap_id", 32'h4FFF_FFFF, 30'h3FFF_FFFF, 1'b1);

        // Reset while a redirect is parked discards it.
        data_rdy = 1'b0; if_busy = 1'b1; br_taken = 1'b1; br_addr = 30'h300;
        tick();
        check("rrw_redir", {31'h0, redir_pend}, 32'h1);
        br_taken = 1'b0; rst = 1'b1;
        tick();
        check("rrw_rst_redir", {31'h0, redir_pend}, 32'h0);
        check("rrw_rst_miss", {16'h0, miss_cnt}, 32'h0);
        rst = 1'b0; if_busy = 1'b0;
        tick();
        check("rrw_if_pc", {2'b00, if_pc}, 32'h0);
        check("rrw_redir2", {31'h0, redir_pend}, 32'h0);

        // Narrow counter saturates at 15.
        busy4 = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("cnt4_14", {28'h0, miss_cnt4}, 32'd14);
        for (int i = 0; i < 6; i++) tick();
        check("cnt4_sat", {28'h0, miss_cnt4}, 32'd15);
        busy4 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
